// File: rtl/resolution_line_loader.sv
// resolution_line_loader: copies the active mode's resolution text lines from the ROM into the OSD text RAM
// Reloads after reset, on any mode change and on a start pulse; a mode change mid-load restarts it.
module resolution_line_loader #(
  parameter int LINE_WIDTH    = 128,
  parameter int NUM_LINES     = 16,
  parameter int MODE_ID_WIDTH = 5,
  parameter int WR_ADDR_WIDTH = 8,
  parameter int TEXT_BASE     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MODE_ID_WIDTH-1:0] mode_id,
  input  logic                     start,
  output logic [3:0]               rom_addr,
  input  logic [LINE_WIDTH-1:0]    rom_q,
  output logic                     wr_en,
  output logic [WR_ADDR_WIDTH-1:0] wr_addr,
  output logic [LINE_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_LINES - 1);
  state_t state_q, state_d;
  logic [MODE_ID_WIDTH-1:0] mode_q;
  logic [3:0] addr_q, addr_d, widx_q;
  logic vld_q, vld_d, pending_q, pending_d;
  logic mode_change, trigger;
  assign mode_change = (mode_id != mode_q) && !reset;
  assign trigger     = start | mode_change | pending_q;
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);
  assign done        = state_q == DONE;
  assign rom_addr    = addr_q;
  assign wr_en       = vld_q;
  assign wr_addr     = WR_ADDR_WIDTH'(TEXT_BASE) + WR_ADDR_WIDTH'(widx_q);
  assign wr_data     = rom_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vld_d     = 1'b0;
    pending_d = pending_q;
    case (state_q)
      IDLE: if (trigger) begin
        state_d   = FETCH;
        addr_d    = 4'd0;
        pending_d = 1'b0;
      end
      FETCH: begin
        vld_d   = 1'b1;
        state_d = (addr_q == LAST) ? DRAIN : FETCH;
        addr_d  = (addr_q == LAST) ? addr_q : addr_q + 4'd1;
      end
      DRAIN: state_d = DONE;
      default: begin
        state_d   = IDLE;
        pending_d = pending_q | start | mode_change;
      end
    endcase
    // a mode change mid-load discards in-flight old-mode data and restarts from line 0
    if (busy && mode_change) begin
      state_d = FETCH;
      addr_d  = 4'd0;
      vld_d   = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      addr_q    <= 4'd0;
      widx_q    <= 4'd0;
      vld_q     <= 1'b0;
      pending_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_id;
      addr_q    <= addr_d;
      widx_q    <= addr_q;
      vld_q     <= vld_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: doc/resolution_line_loader.md
Name: resolution_line_loader

Overview:
- Downstream consumer of the per-mode resolution text ROM.
- On reset release, on a video mode change, or on an explicit start pulse, it walks the ROM line addresses 0..NUM_LINES-1 and accounts for the ROM's 1-cycle registered read latency.
- It writes each returned text line into the OSD text RAM at TEXT_BASE+index, then pulses done.
- Keeps the on-screen resolution label in sync with the active mode without CPU involvement.

Parameters:
- LINE_WIDTH, 128: width of one resolution text line (ROM q width, RAM write data width).
- NUM_LINES, 16: lines per mode; range 1..16 (ROM address is 4 bits).
- MODE_ID_WIDTH, 5: width of the mode identifier.
- WR_ADDR_WIDTH, 8: text RAM address width.
- TEXT_BASE, 0: RAM address that receives line 0.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_id  in  MODE_ID_WIDTH  active mode id; the same value drives the ROM's mode select.
- start  in  1  single-cycle request to reload the current mode's text.
- rom_addr  out  4  line address to the resolution ROM.
- rom_q  in  LINE_WIDTH  ROM data; valid one cycle after rom_addr is presented.
- wr_en  out  1  text RAM write strobe.
- wr_addr  out  WR_ADDR_WIDTH  text RAM write address.
- wr_data  out  LINE_WIDTH  text RAM write data; equals rom_q combinationally.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load completes without abort.

Behaviour:
- Reset values: rom_addr=0, wr_en=0, wr_addr=TEXT_BASE, busy=0, done=0, state=IDLE, mode_q=0, pending=1. The pending flag forces one load after reset deasserts.
- mode_q registers mode_id every cycle.
- mode_change = (mode_id != mode_q) and not in reset.
- trigger = start | mode_change | pending.
- States:
  - IDLE: on trigger -> FETCH, idx=0, pending cleared.
  - FETCH: rom_addr=idx; a valid bit vld (registered) marks that the previous cycle issued an address. idx increments each cycle. When idx == NUM_LINES-1 is issued -> DRAIN.
  - DRAIN: writes the final line, then -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE. If trigger is present in DONE, the next load starts from IDLE the following cycle.
- Write pipeline: wr_en = vld; wr_addr = TEXT_BASE + (index issued one cycle earlier); wr_data = rom_q.
- Latency: trigger seen in cycle T.
  - T+1: rom_addr=0, busy=1.
  - T+2: first write (line 0).
  - T+NUM_LINES+1: last write, line NUM_LINES-1.
  - T+NUM_LINES+2: done=1.
- busy is high T+1 .. T+NUM_LINES+1 inclusive.
- Exactly NUM_LINES writes per completed load, with consecutive ascending addresses and no gaps.
- NUM_LINES=1: FETCH lasts one cycle, then DRAIN, then DONE.
- start while busy and mode unchanged: ignored (no queuing).
- mode_change while busy (FETCH or DRAIN): abort.
  - The next cycle restarts FETCH at idx=0, vld cleared, so no write carries data fetched under the old mode after the change cycle.
  - No done pulse for the aborted load.
  - RAM content already written is simply overwritten by the restarted load.
- start and mode_change in the same cycle: one load only.
- reset mid-load: all outputs return to reset values on the next edge; no further writes; a fresh load follows deassertion via pending.
- rom_addr holds its last value in IDLE/DONE; the ROM tolerates any address.

Test Plan:
- Reset release, NUM_LINES=16, TEXT_BASE=0x20, mode_id=3, rom_q=0xA0+addr:
  - done at cycle 18 after reset deassert; 16 writes to 0x20..0x2F with data 0xA0..0xAF.
  - busy high cycles 1..17.
- Idle, mode_id 3->7 at cycle T: first write at T+2 to 0x20, done at T+18, no extra writes afterwards.
- start pulse during load (cycle 5 of FETCH), mode stable: load completes unchanged, single done, no second load.
- mode_id change at 6th write of a load:
  - aborted load gives no done.
  - the restarted load writes 0x20..0x2F with new-mode data.
  - done 18 cycles after the change.
  - no write in between carries old-mode data after the change cycle.
- reset asserted at write 10 for 2 cycles: wr_en=0 and busy=0 during reset; after release a full 16-line load and done pulse.
- NUM_LINES=1 build: trigger -> single write at T+2, done at T+3.
